// File: rtl/rsp_s2_cmp_frame_count.sv
// Per-frame clean/total lane counter with valid/ready result hold for the RSP abs-compare chain.
// Optional macro RSP_CMP_CNT_SAT_EN: saturating counters with a sticky o_sat flag per frame.
module rsp_s2_cmp_frame_count #(
  parameter int unsigned NUM       = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_switch,
  input  logic [NUM-1:0]       i_rcmp,
  input  logic                 i_rcmp_valid,
  input  logic [NUM/2-1:0]     i_ccmp,
  input  logic                 i_ccmp_valid,
  input  logic                 i_last,
  input  logic [CNT_WIDTH-1:0] i_thresh,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [CNT_WIDTH-1:0] o_clean_cnt,
  output logic [CNT_WIDTH-1:0] o_total_cnt,
  output logic                 o_pass,
  output logic                 o_mode,
  output logic                 o_drop,
  output logic                 o_sat
);

  localparam int unsigned CNUM = NUM / 2;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t               state, state_nxt;
  logic                 mode_q, mode_sel, beat, accept, fresh, drop;
  logic [CNT_WIDTH-1:0] acc_clean, acc_total;
  logic [CNT_WIDTH-1:0] pop, lanes, base_clean, base_total, nxt_clean, nxt_total;

  // HOLD with i_ready behaves like IDLE: a coincident beat starts a fresh frame.
  always_comb begin
    mode_sel   = (state == ACC) ? mode_q : i_switch;
    beat       = mode_sel ? i_rcmp_valid : i_ccmp_valid;
    accept     = beat && ((state != HOLD) || i_ready);
    drop       = beat && (state == HOLD) && !i_ready;
    fresh      = (state != ACC);
    pop        = '0;
    if (mode_sel) begin
      for (int unsigned i = 0; i < NUM; i++) pop = pop + CNT_WIDTH'(i_rcmp[i]);
    end else begin
      for (int unsigned i = 0; i < CNUM; i++) pop = pop + CNT_WIDTH'(i_ccmp[i]);
    end
    lanes      = mode_sel ? CNT_WIDTH'(NUM) : CNT_WIDTH'(CNUM);
    base_clean = fresh ? '0 : acc_clean;
    base_total = fresh ? '0 : acc_total;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = i_last ? HOLD : ACC;
      ACC:  if (accept && i_last) state_nxt = HOLD;
      HOLD: if (i_ready) state_nxt = accept ? (i_last ? HOLD : ACC) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef RSP_CMP_CNT_SAT_EN
  logic [CNT_WIDTH:0] sum_clean, sum_total;
  logic               acc_sat, nxt_sat;

  always_comb begin
    sum_clean = {1'b0, base_clean} + {1'b0, pop};
    sum_total = {1'b0, base_total} + {1'b0, lanes};
    nxt_clean = sum_clean[CNT_WIDTH] ? '1 : sum_clean[CNT_WIDTH-1:0];
    nxt_total = sum_total[CNT_WIDTH] ? '1 : sum_total[CNT_WIDTH-1:0];
    nxt_sat   = (fresh ? 1'b0 : acc_sat) | sum_clean[CNT_WIDTH] | sum_total[CNT_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sat <= 1'b0;
      o_sat   <= 1'b0;
    end else if (accept) begin
      acc_sat <= nxt_sat;
      if (i_last) o_sat <= nxt_sat;
    end
  end
`else
  always_comb begin
    nxt_clean = base_clean + pop;
    nxt_total = base_total + lanes;
  end

  assign o_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_clean   <= '0;
      acc_total   <= '0;
      mode_q      <= 1'b0;
      o_valid     <= 1'b0;
      o_clean_cnt <= '0;
      o_total_cnt <= '0;
      o_pass      <= 1'b0;
      o_mode      <= 1'b0;
      o_drop      <= 1'b0;
    end else begin
      o_drop <= drop;
      if (accept) begin
        acc_clean <= nxt_clean;
        acc_total <= nxt_total;
        mode_q    <= mode_sel;
      end
      if (accept && i_last) begin
        o_valid     <= 1'b1;
        o_clean_cnt <= nxt_clean;
        o_total_cnt <= nxt_total;
        o_pass      <= (nxt_clean >= i_thresh);
        o_mode      <= mode_sel;
      end else if ((state == HOLD) && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
